scan_bist_controller: RTL and testbench
=======================================

Name: scan_bist_controller

Overview:
- On-chip BIST master for a single scan chain; it drives the opposite end of the chain interface.
- Generates pseudo-random scan-in patterns with an LFSR and drives the chain's serial input and test_control (1 = shift, 0 = capture/hold).
- Compacts the chain's serial output into a MISR signature, then reports done and pass.
- Sits between the test access logic (start/done/pass) and one scan chain instance.

Parameters:
- CHAIN_LEN, 7, number of scan cells in the chain.
- NUM_PATTERNS, 16, number of load/capture patterns applied (>=1).
- LFSR_W, 16, pattern LFSR width.
- LFSR_TAPS, 16'hB400, Fibonacci feedback tap mask.
- LFSR_SEED, 16'hACE1, LFSR reset/restart value; 0 is replaced by 1.
- MISR_W, 16, signature width.
- MISR_POLY, 16'h1021, MISR feedback polynomial.
- GOLDEN_SIG, 16'h0000, expected signature (used only with the optional feature).

Ports:
- clock  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to run a BIST session.
- scan_in_drv  out  1  serial data to the chain's scan input.
- scan_out_mon  in  1  serial data from the chain's (registered) scan output.
- test_control  out  1  chain mode: 1 = shift, 0 = capture/hold.
- busy  out  1  session in progress.
- done  out  1  session complete; held until the next start.
- pass  out  1  signature matched (see Optional Feature).
- signature  out  MISR_W  current MISR contents.
- pattern_count  out  clog2(NUM_PATTERNS+1)  patterns fully loaded and captured.

Behaviour:
- Reset (async, any state): state = IDLE; test_control, scan_in_drv, busy, done, pass = 0; signature = 0; pattern_count = 0; LFSR = LFSR_SEED.
- All outputs are registered.
- States:
  - IDLE --start--> SHIFT.
  - SHIFT: test_control = 1 for CHAIN_LEN+1 cycles. The extra cycle covers the chain's output register. scan_in_drv = lfsr[0]; the LFSR advances each SHIFT cycle. Then go to CAPTURE.
  - CAPTURE: test_control = 0 for 1 cycle; pattern_count += 1. If pattern_count reaches NUM_PATTERNS, go to UNLOAD; otherwise go to SHIFT.
  - UNLOAD: test_control = 1 for CHAIN_LEN+1 cycles; scan_in_drv = 0; the LFSR holds. Then go to DRAIN.
  - DRAIN: 1 cycle, test_control = 0; the MISR takes its final sample. Then go to DONE.
  - DONE: busy = 0, done = 1, signature frozen. start returns to SHIFT.
- Session start (start in IDLE or DONE): the LFSR is reloaded with LFSR_SEED and signature, pattern_count and done are cleared on the same edge. busy = 1 from the next cycle until DONE.
- start in SHIFT, CAPTURE, UNLOAD or DRAIN is ignored.
- LFSR rule: next = {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)}.
- MISR sampling: the MISR updates on every edge where test_control was 1 during the preceding cycle, i.e. one cycle after each chain shift edge.
- MISR rule: m = (sig << 1) ^ (sig[MISR_W-1] ? MISR_POLY : 0); then m[0] ^= scan_out_mon.
- The unload window of the first pattern (reset contents of the chain) is compacted too; it is deterministic.
- Session length: 1 + NUM_PATTERNS*(CHAIN_LEN+2) + (CHAIN_LEN+1) + 1 cycles from the start-sampling edge to done rising.

Optional Feature:
- Macro: BIST_SIG_CHECK_EN.
- Defined: on entry to DONE, pass = (signature == GOLDEN_SIG); pass is held until the next start or reset.
- Undefined: no comparator is built, pass is tied to 0, and GOLDEN_SIG is unused. The signature is read externally.

Test Plan:
- Reset mid-SHIFT (assert reset 3 cycles after start) -> same cycle: test_control = 0, busy = 0, signature = 0, pattern_count = 0. A following start runs a full, correct session.
- Defaults except NUM_PATTERNS = 2, start at edge 0 -> required sequence:
  - test_control = 1 on cycles 1–8, 0 on cycle 9, 1 on 10–17, 0 on 18, 1 on 19–26 (UNLOAD, scan_in_drv = 0), 0 on 27 (DRAIN).
  - done = 1 from cycle 28; pattern_count = 2.
- scan_out_mon tied 0 for a full default session -> signature = 16'h0000 at DONE. With BIST_SIG_CHECK_EN and GOLDEN_SIG = 0, pass = 1.
- Default parameters, bench models the chain as a CHAIN_LEN+1 flop delay enabled by test_control -> scan_in_drv first 8 bits after start are LFSR bit 0 of seed 16'hACE1 and its successors. Final signature equals the bench's bit-accurate LFSR/MISR model.
- start pulsed during SHIFT and CAPTURE -> ignored; cycle count and signature are identical to an undisturbed run. start in DONE -> restart: done = 0 next cycle, signature cleared, same final signature as the first run.
- scan_out_mon tied 1, BIST_SIG_CHECK_EN defined, GOLDEN_SIG = 0 -> signature nonzero and equal to the model's value, pass = 0.

Source files
------------

// File: rtl/scan_bist_controller.sv
// Scan-chain BIST master: LFSR pattern generation, shift/capture sequencing, MISR compaction.
// Optional signature comparator enabled by defining BIST_SIG_CHECK_EN.
module scan_bist_controller #(
   parameter int unsigned       CHAIN_LEN    = 7,
   parameter int unsigned       NUM_PATTERNS = 16,
   parameter int unsigned       LFSR_W       = 16,
   parameter logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400,
   parameter logic [LFSR_W-1:0] LFSR_SEED    = 16'hACE1,
   parameter int unsigned       MISR_W       = 16,
   parameter logic [MISR_W-1:0] MISR_POLY    = 16'h1021,
   parameter logic [MISR_W-1:0] GOLDEN_SIG   = 16'h0000,
   localparam int unsigned      PC_W         = $clog2(NUM_PATTERNS + 1)
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              start_i,
   output logic              scan_in_drv_o,
   input  logic              scan_out_mon_i,
   output logic              test_control_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              pass_o,
   output logic [MISR_W-1:0] signature_o,
   output logic [PC_W-1:0]   pattern_count_o
);

   localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 2);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN);
   localparam logic [PC_W-1:0] LAST_PAT = PC_W'(NUM_PATTERNS - 1);
   localparam logic [LFSR_W-1:0] SEED_EFF =
      (LFSR_SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : LFSR_SEED;

   if (NUM_PATTERNS < 1 || LFSR_W < 2 || MISR_W < 2 || $bits(GOLDEN_SIG) != MISR_W) begin : g_param_err
      $error("scan_bist_controller: illegal parameter set");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_SHIFT, S_CAPTURE, S_UNLOAD, S_DRAIN, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [LFSR_W-1:0]   lfsr_q, lfsr_d, lfsr_src;
   logic [MISR_W-1:0]   sig_q, sig_d;
   logic                scan_in_q, scan_in_d;
   logic                tc_q, busy_q, done_q;
   logic                misr_en_q;
   logic                start_ok;
`ifdef BIST_SIG_CHECK_EN
   logic                pass_q, pass_d;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pc_d      = pc_q;
      lfsr_d    = lfsr_q;
      sig_d     = sig_q;
      scan_in_d = 1'b0;
`ifdef BIST_SIG_CHECK_EN
      pass_d    = pass_q;
`endif
      start_ok  = start_i && (state_q == S_IDLE || state_q == S_DONE);
      lfsr_src  = start_ok ? SEED_EFF : lfsr_q;

      // Sample one cycle after each shift edge so the chain's output register has settled
      if (misr_en_q) begin
         sig_d    = {sig_q[MISR_W-2:0], 1'b0} ^ (sig_q[MISR_W-1] ? MISR_POLY : '0);
         sig_d[0] = sig_d[0] ^ scan_out_mon_i;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_ok) begin
               state_d = S_SHIFT;
               cnt_d   = '0;
               pc_d    = '0;
               sig_d   = '0;
`ifdef BIST_SIG_CHECK_EN
               pass_d  = 1'b0;
`endif
            end
         end
         S_SHIFT: begin
            if (cnt_q == LAST_CNT) state_d = S_CAPTURE;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         S_CAPTURE: begin
            pc_d    = pc_q + 1'b1;
            cnt_d   = '0;
            state_d = (pc_q == LAST_PAT) ? S_UNLOAD : S_SHIFT;
         end
         S_UNLOAD: begin
            if (cnt_q == LAST_CNT) state_d = S_DRAIN;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         S_DRAIN: begin
            state_d = S_DONE;
`ifdef BIST_SIG_CHECK_EN
            pass_d  = (sig_d == GOLDEN_SIG);
`endif
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d == S_SHIFT) begin
         scan_in_d = lfsr_src[0];
         lfsr_d    = {lfsr_src[LFSR_W-2:0], ^(lfsr_src & LFSR_TAPS)};
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         pc_q      <= '0;
         lfsr_q    <= SEED_EFF;
         sig_q     <= '0;
         scan_in_q <= 1'b0;
         tc_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         misr_en_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pc_q      <= pc_d;
         lfsr_q    <= lfsr_d;
         sig_q     <= sig_d;
         scan_in_q <= scan_in_d;
         tc_q      <= (state_d == S_SHIFT) || (state_d == S_UNLOAD);
         busy_q    <= (state_d != S_IDLE) && (state_d != S_DONE);
         done_q    <= (state_d == S_DONE);
         misr_en_q <= tc_q;
      end
   end

`ifdef BIST_SIG_CHECK_EN
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) pass_q <= 1'b0;
      else         pass_q <= pass_d;
   end
   assign pass_o = pass_q;
`else
   assign pass_o = 1'b0;
`endif

   assign scan_in_drv_o   = scan_in_q;
   assign test_control_o  = tc_q;
   assign busy_o          = busy_q;
   assign done_o          = done_q;
   assign signature_o     = sig_q;
   assign pattern_count_o = pc_q;

endmodule

// File: tb/tb_scan_bist_controller.sv
// Directed bench for scan_bist_controller: default instance plus a NUM_PATTERNS=2 instance.
module tb_scan_bist_controller;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   // Default-parameter DUT with a bench-side scan chain model
   logic        start_a = 1'b0;
   logic        si_a, tc_a, busy_a, done_a, pass_a, mon_a;
   logic [15:0] sig_a;
   logic [4:0]  pc_a;
   logic [7:0]  chain_a;
   int          mode_a = 2;

   // NUM_PATTERNS = 2 DUT
   logic        start_b = 1'b0;
   logic        si_b, tc_b, busy_b, done_b, pass_b;
   logic        mon_b = 1'b0;
   logic [15:0] sig_b;
   logic [1:0]  pc_b;

   logic        exp_pass_tie0;
   logic [7:0]  si_first;
   logic [7:0]  si_hand;
   logic [15:0] sig_ref;
   logic        first_done, first_busy;
   logic [15:0] first_sig;
   int          cycles;
   bit          tmo;

   scan_bist_controller u_dut_a (
      .clock_i(clk), .reset_i(rst), .start_i(start_a),
      .scan_in_drv_o(si_a), .scan_out_mon_i(mon_a), .test_control_o(tc_a),
      .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
      .signature_o(sig_a), .pattern_count_o(pc_a)
   );

   scan_bist_controller #(.NUM_PATTERNS(2)) u_dut_b (
      .clock_i(clk), .reset_i(rst), .start_i(start_b),
      .scan_in_drv_o(si_b), .scan_out_mon_i(mon_b), .test_control_o(tc_b),
      .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
      .signature_o(sig_b), .pattern_count_o(pc_b)
   );

   // Chain = CHAIN_LEN cells plus the registered output, shifting while test_control is high
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       chain_a <= '0;
      else if (tc_a) chain_a <= {chain_a[6:0], si_a};
   end
   assign mon_a = (mode_a == 0) ? 1'b0 : (mode_a == 1) ? 1'b1 : chain_a[7];

   // Reference signature built from the schedule, LFSR stream, chain delay and MISR rule
   function automatic logic [15:0] model_sig(input int mode, input int npat);
      logic [15:0] lf = 16'hACE1;
      logic [15:0] m  = 16'h0000;
      logic [7:0]  ch = 8'h00;
      bit          tc_prev = 1'b0;
      bit          so;
      int          last = npat * 9 + 9;
      for (int k = 1; k <= last; k++) begin
         bit tc;
         bit si;
         if (k <= npat * 9) begin
            tc = (((k - 1) % 9) != 8);
            si = tc ? lf[0] : 1'b0;
         end else begin
            tc = (k < last);
            si = 1'b0;
         end
         so = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : ch[7];
         if (tc_prev) m = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {15'b0, so};
         if (tc && k <= npat * 9) lf = {lf[14:0], ^(lf & 16'hB400)};
         if (tc) ch = {ch[6:0], si};
         tc_prev = tc;
      end
      return m;
   endfunction

   // Runs one session on DUT A; optionally pulses start during SHIFT (cycle 3) and CAPTURE (cycle 9)
   task automatic run_a(input bit inject, output int cyc, output bit timeout);
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      cyc = 1;
      first_done = done_a;
      first_busy = busy_a;
      first_sig  = sig_a;
      si_first[0] = si_a;
      while (!done_a && cyc < 400) begin
         start_a = inject && (cyc == 3 || cyc == 9);
         @(negedge clk);
         cyc++;
         if (cyc <= 8) si_first[cyc-1] = si_a;
      end
      start_a = 1'b0;
      timeout = !done_a;
      $display("session mode=%0d inject=%0d cycles=%0d sig=%04h pc=%0d pass=%0b",
               mode_a, inject, cyc, sig_a, pc_a, pass_a);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_cmp++; if (tc_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got tc=%b busy=%b done=%b want 0 0 0", tc_a, busy_a, done_a);
      end
      n_cmp++; if (sig_a !== 16'h0000 || pc_a !== 5'd0) begin
         n_fail++; $display("FAIL reset_sig: got sig=%04h pc=%0d want 0000 0", sig_a, pc_a);
      end
      n_cmp++; if (si_a !== 1'b0 || pass_a !== 1'b0) begin
         n_fail++; $display("FAIL reset_si_pass: got si=%b pass=%b want 0 0", si_a, pass_a);
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (tc_b !== 1'b0 || busy_b !== 1'b0 || done_b !== 1'b0 || pc_b !== 2'd0) begin
         n_fail++; $display("FAIL idle_b: got tc=%b busy=%b done=%b pc=%0d want 0 0 0 0", tc_b, busy_b, done_b, pc_b);
      end
      $display("reset checks done");
   endtask

   task automatic test_reset_mid_shift();
      mode_a = 2;
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (tc_a !== 1'b1 || busy_a !== 1'b1) begin
         n_fail++; $display("FAIL pre_reset_shift: got tc=%b busy=%b want 1 1", tc_a, busy_a);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (tc_a !== 1'b0 || busy_a !== 1'b0 || sig_a !== 16'h0000 || pc_a !== 5'd0) begin
         n_fail++; $display("FAIL async_reset: got tc=%b busy=%b sig=%04h pc=%0d want 0 0 0000 0", tc_a, busy_a, sig_a, pc_a);
      end
      @(negedge clk);
      rst = 1'b0;
      run_a(1'b0, cycles, tmo);
      n_cmp++; if (tmo || cycles !== 154) begin
         n_fail++; $display("FAIL post_reset_len: got cycles=%0d timeout=%0b want 154 0", cycles, tmo);
      end
      n_cmp++; if (sig_a !== model_sig(2, 16) || pc_a !== 5'd16) begin
         n_fail++; $display("FAIL post_reset_sig: got sig=%04h pc=%0d want %04h 16", sig_a, pc_a, model_sig(2, 16));
      end
   endtask

   task automatic test_short_session();
      logic exp_tc;
      @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      for (int k = 1; k <= 28; k++) begin
         exp_tc = (k <= 8) || (k >= 10 && k <= 17) || (k >= 19 && k <= 26);
         n_cmp++; if (tc_b !== exp_tc) begin
            n_fail++; $display("FAIL short_tc cycle %0d: got %b want %b", k, tc_b, exp_tc);
         end
         if (k >= 19 && k <= 26) begin
            n_cmp++; if (si_b !== 1'b0) begin
               n_fail++; $display("FAIL short_unload_si cycle %0d: got %b want 0", k, si_b);
            end
         end
         n_cmp++; if (done_b !== (k == 28)) begin
            n_fail++; $display("FAIL short_done cycle %0d: got %b want %b", k, done_b, (k == 28));
         end
         if (k < 28) @(negedge clk);
      end
      n_cmp++; if (pc_b !== 2'd2 || busy_b !== 1'b0 || sig_b !== 16'h0000) begin
         n_fail++; $display("FAIL short_end: got pc=%0d busy=%b sig=%04h want 2 0 0000", pc_b, busy_b, sig_b);
      end
      $display("short session (2 patterns) checked");
   endtask

   task automatic test_tie0();
      mode_a = 0;
      run_a(1'b0, cycles, tmo);
      n_cmp++; if (tmo || sig_a !== 16'h0000) begin
         n_fail++; $display("FAIL tie0_sig: got %04h timeout=%0b want 0000", sig_a, tmo);
      end
      n_cmp++; if (pass_a !== exp_pass_tie0) begin
         n_fail++; $display("FAIL tie0_pass: got %b want %b", pass_a, exp_pass_tie0);
      end
      n_cmp++; if (done_a !== 1'b1 || busy_a !== 1'b0) begin
         n_fail++; $display("FAIL tie0_flags: got done=%b busy=%b want 1 0", done_a, busy_a);
      end
   endtask

   task automatic test_chain();
      mode_a = 2;
      run_a(1'b0, cycles, tmo);
      n_cmp++; if (si_first !== si_hand) begin
         n_fail++; $display("FAIL chain_scan_in: got %08b want %08b (bit0 first)", si_first, si_hand);
      end
      n_cmp++; if (tmo || cycles !== 154) begin
         n_fail++; $display("FAIL chain_len: got cycles=%0d want 154", cycles);
      end
      n_cmp++; if (sig_a !== model_sig(2, 16)) begin
         n_fail++; $display("FAIL chain_sig: got %04h want %04h", sig_a, model_sig(2, 16));
      end
      sig_ref = model_sig(2, 16);
   endtask

   task automatic test_start_ignored();
      mode_a = 2;
      run_a(1'b1, cycles, tmo);
      n_cmp++; if (tmo || cycles !== 154) begin
         n_fail++; $display("FAIL ignored_len: got cycles=%0d want 154", cycles);
      end
      n_cmp++; if (sig_a !== sig_ref) begin
         n_fail++; $display("FAIL ignored_sig: got %04h want %04h", sig_a, sig_ref);
      end
   endtask

   task automatic test_restart();
      mode_a = 2;
      run_a(1'b0, cycles, tmo);
      n_cmp++; if (first_done !== 1'b0 || first_busy !== 1'b1 || first_sig !== 16'h0000) begin
         n_fail++; $display("FAIL restart_clear: got done=%b busy=%b sig=%04h want 0 1 0000", first_done, first_busy, first_sig);
      end
      n_cmp++; if (tmo || sig_a !== sig_ref) begin
         n_fail++; $display("FAIL restart_sig: got %04h want %04h", sig_a, sig_ref);
      end
   endtask

   task automatic test_tie1();
      mode_a = 1;
      run_a(1'b0, cycles, tmo);
      n_cmp++; if (tmo || sig_a === 16'h0000) begin
         n_fail++; $display("FAIL tie1_nonzero: got %04h want nonzero", sig_a);
      end
      n_cmp++; if (sig_a !== model_sig(1, 16)) begin
         n_fail++; $display("FAIL tie1_sig: got %04h want %04h", sig_a, model_sig(1, 16));
      end
      n_cmp++; if (pass_a !== 1'b0) begin
         n_fail++; $display("FAIL tie1_pass: got %b want 0", pass_a);
      end
   endtask

   initial begin
      // LFSR bit 0 for seed ACE1 and its first seven successors, bit 0 = first shifted
      si_hand = 8'h4F;
`ifdef BIST_SIG_CHECK_EN
      exp_pass_tie0 = 1'b1;
`else
      exp_pass_tie0 = 1'b0;
`endif
      test_reset();
      test_reset_mid_shift();
      test_short_session();
      test_tie0();
      test_chain();
      test_start_ignored();
      test_restart();
      test_tie1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
